// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: memory request/response plus downstream inst handshake.
// master = fetch stage, slave = memory / decode / execute side.
interface inst_fetch_if #(
  parameter int XLEN = 64
);
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [31:0]     mem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data,
    output inst_valid,
    output inst,
    output inst_pc,
    input  inst_ready,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    output inst_ready,
    output redirect_valid,
    output redirect_pc
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding word request, redirect aware.
// Optional perf counters enabled with INST_FETCH_PERF_EN.
module inst_fetch #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  inst_fetch_if.master bus
`ifdef INST_FETCH_PERF_EN
  , output logic [63:0] perf_fetch_cnt
  , output logic [63:0] perf_stall_cnt
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]      state_q;
  logic [1:0]      state_d;
  logic            drop_q;
  logic            drop_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] req_addr_q;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic [XLEN-1:0] redir_pc;
  logic            hs_inst;
  logic            unused_lo;

  assign redir_pc  = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign unused_lo = ^bus.redirect_pc[1:0];
  assign hs_inst   = (state_q == HOLD) && bus.inst_ready;

  always_comb begin
    pc_d = pc_q;
    if (bus.redirect_valid)
      pc_d = redir_pc;
    else if (hs_inst)
      pc_d = pc_q + XLEN'(4);
  end

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (bus.mem_req_ready)
          state_d = WAIT;
        if (bus.redirect_valid)
          drop_d = 1'b1;
      end
      WAIT: begin
        if (bus.mem_rsp_valid) begin
          // Stale response: the one outstanding request is now retired
          if (drop_q || bus.redirect_valid) begin
            state_d = REQ;
            drop_d  = 1'b0;
          end else begin
            state_d = HOLD;
          end
        end else if (bus.redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (bus.inst_ready || bus.redirect_valid)
          state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      drop_q     <= 1'b0;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      pc_q    <= pc_d;
      if (state_d == REQ && state_q != REQ)
        req_addr_q <= pc_d;
      if (state_q == WAIT && state_d == HOLD) begin
        inst_q    <= bus.mem_rsp_data;
        inst_pc_q <= req_addr_q;
      end
    end
  end

  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.inst_valid    = (state_q == HOLD);
  assign bus.inst          = inst_q;
  assign bus.inst_pc       = inst_pc_q;

`ifdef INST_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (hs_inst)
        perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if (state_q == REQ || state_q == WAIT)
        perf_stall_cnt <= perf_stall_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: hand-computed addresses and data.
// Inputs driven and outputs sampled 1ns after the rising edge.
module tb_inst_fetch;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  inst_fetch_if #(.XLEN(64)) bus ();

`ifdef INST_FETCH_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
`endif

  inst_fetch #(
    .XLEN     (64),
    .RESET_PC (64'h8000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
`ifdef INST_FETCH_PERF_EN
    , .perf_fetch_cnt (perf_fetch_cnt)
    , .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [63:0] addr);
    chk("req_valid", 64'(bus.mem_req_valid), 64'd1);
    chk("req_addr", bus.mem_req_addr, addr);
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    chk("wait_noreq", 64'(bus.mem_req_valid), 64'd0);
  endtask

  task automatic rsp(input logic [31:0] data);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = data;
    step();
    bus.mem_rsp_valid = 1'b0;
  endtask

  task automatic hold(input logic [31:0] data, input logic [63:0] pc);
    chk("inst_valid", 64'(bus.inst_valid), 64'd1);
    chk("inst", 64'(bus.inst), 64'(data));
    chk("inst_pc", bus.inst_pc, pc);
  endtask

  task automatic accept();
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
  endtask

  task automatic fetch(input logic [63:0] addr, input logic [31:0] data);
    req(addr);
    rsp(data);
    hold(data, addr);
    accept();
  endtask

  task automatic chk_reset();
    chk("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    chk("rst_req_addr", bus.mem_req_addr, 64'd0);
    chk("rst_inst", 64'(bus.inst), 64'd0);
    chk("rst_inst_pc", bus.inst_pc, 64'd0);
`ifdef INST_FETCH_PERF_EN
    chk("rst_perf_fetch", perf_fetch_cnt, 64'd0);
    chk("rst_perf_stall", perf_stall_cnt, 64'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n              = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_data   = '0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (3) step();
    chk_reset();

    rst_n = 1'b1;
    chk("idle_noreq", 64'(bus.mem_req_valid), 64'd0);
    step();

    // sequential fetch, one instruction every 3 cycles
    fetch(64'h8000_0000, 32'hA000_0000);
    fetch(64'h8000_0004, 32'hA000_0001);
    fetch(64'h8000_0008, 32'hA000_0002);
`ifdef INST_FETCH_PERF_EN
    chk("perf_fetch", perf_fetch_cnt, 64'd3);
    chk("perf_stall", perf_stall_cnt, 64'd6);
`endif

    // downstream stall in HOLD
    req(64'h8000_000C);
    rsp(32'hA000_0003);
    for (int i = 0; i < 5; i++) begin
      hold(32'hA000_0003, 64'h8000_000C);
      chk("stall_noreq", 64'(bus.mem_req_valid), 64'd0);
      step();
    end
    hold(32'hA000_0003, 64'h8000_000C);
    accept();

    // redirect together with inst_ready in HOLD
    req(64'h8000_0010);
    rsp(32'hA000_0004);
    hold(32'hA000_0004, 64'h8000_0010);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_3000;
    bus.inst_ready     = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b0;
    chk("hold_redir_noinst", 64'(bus.inst_valid), 64'd0);
    fetch(64'h8000_3000, 32'hA000_0005);

    // mem_req_ready low with an unaligned redirect mid-wait
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", 64'(bus.mem_req_valid), 64'd1);
      chk("bp_addr", bus.mem_req_addr, 64'h8000_3004);
      if (i == 1) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h8000_1002;
      end
      step();
      bus.redirect_valid = 1'b0;
    end
    req(64'h8000_3004);
    rsp(32'hA000_0006);
    chk("drop_noinst", 64'(bus.inst_valid), 64'd0);
    fetch(64'h8000_1000, 32'hA000_0007);

    // redirect in the same cycle as the response
    req(64'h8000_1004);
    bus.mem_rsp_valid  = 1'b1;
    bus.mem_rsp_data   = 32'hA000_0008;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_2000;
    step();
    bus.mem_rsp_valid  = 1'b0;
    bus.redirect_valid = 1'b0;
    chk("rsp_redir_noinst", 64'(bus.inst_valid), 64'd0);
    req(64'h8000_2000);

    // reset while in WAIT, then a late response
    rst_n = 1'b0;
    #2;
    chk_reset();
    rst_n             = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hDEAD_BEEF;
    step();
    chk("late_noinst0", 64'(bus.inst_valid), 64'd0);
    chk("late_req_valid", 64'(bus.mem_req_valid), 64'd1);
    chk("late_req_addr", bus.mem_req_addr, 64'h8000_0000);
    step();
    chk("late_noinst1", 64'(bus.inst_valid), 64'd0);
    bus.mem_rsp_valid = 1'b0;
    fetch(64'h8000_0000, 32'hA000_0009);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
